// File: rtl/signed_subtractor_serial.sv
// signed_subtractor_serial: bit-serial two's-complement A - B (A + ~B + 1), LSB first,
// with start/busy/done handshake and signed overflow flag.
module signed_subtractor_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_sa, r_sb, r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             w_d, w_cout, w_last;

    assign w_d    = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_cout = (r_sa[0] & r_sb[0]) | (r_c & (r_sa[0] | r_sb[0]));
    assign w_last = r_cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE:    w_next = start ? SHIFT : IDLE;
            SHIFT: begin
                busy   = 1'b1;
                w_next = w_last ? DONE : SHIFT;
            end
            DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // the carry into the MSB is r_c on the last edge, the carry out is w_cout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            DIFF     <= '0;
            overflow <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_sa  <= A;
            r_sb  <= ~B;
            r_c   <= 1'b1;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_c   <= w_cout;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                DIFF     <= {w_d, r_res[WIDTH-1:1]};
                overflow <= r_c ^ w_cout;
            end
        end
    end
endmodule

// File: tb/tb_signed_subtractor_serial.sv
// tb_signed_subtractor_serial: scoreboard bench; expected results queued at acceptance,
// compared when done pulses, with per-cycle handshake and output-hold checks.
module tb_signed_subtractor_serial;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b1;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, overflow;
    logic [W-1:0] DIFF;

    signed_subtractor_serial #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .DIFF(DIFF), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [W:0] q[$];
    logic [W:0] m_last = '0;
    int         m_cnt = 0;
    bit         m_rst = 1'b0;
    bit         armed = 1'b0;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int d;
        d = int'($signed(a)) - int'($signed(b));
        return {(d > 7) || (d < -8), W'(d)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // acceptance model: idle when m_cnt==0, done expected when m_cnt==1
    always @(posedge clk) begin
        m_rst = !rst_n;
        if (!rst_n) begin
            m_cnt = 0;
            armed = 1'b1;
        end else if (m_cnt == 0) begin
            if (start) begin
                q.push_back(model(A, B));
                m_cnt = W + 1;
            end
        end else begin
            m_cnt--;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (m_rst) begin
                q.delete();
                m_last = '0;
            end
            check("busy", busy, m_cnt > 0);
            check("done", done, m_cnt == 1);
            if (done) begin
                check("q_pop", q.size() > 0, 1);
                if (q.size() > 0) m_last = q.pop_front();
            end
            check("diff", DIFF, m_last[W-1:0]);
            check("ovf", overflow, m_last[W]);
        end
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        B = ~b;
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        op(4'b0010, 4'b0011);
        op(4'b0110, 4'b1011);
        op(4'b1010, 4'b0100);
        op(4'b1011, 4'b1101);
        op(4'b1000, 4'b0001);
        op(4'b0000, 4'b1000);
        op(4'b0111, 4'b0111);
        op(4'b1000, 4'b0000);
        op(4'b0011, 4'b1000);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 2) @(negedge clk);
        A = 4'b0101;
        B = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        op(4'b0101, 4'b0001);
        repeat (2) @(negedge clk);
        check("q_left", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
